// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared definitions for the Goldschmidt divider control slice.
//   fpdiv_state_t  controller state encoding
//   MUXA_*         A-mux select codes (REGA, d, initial approximation)
//   MUXB_*         B-mux select codes (d, x, REGB, REGC)
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    ITER_N = 3'd3,
    ITER_D = 3'd4,
    DONE   = 3'd5
  } fpdiv_state_t;

  localparam logic [1:0] MUXA_REGA = 2'b00;
  localparam logic [1:0] MUXA_D    = 2'b01;
  localparam logic [1:0] MUXA_IA   = 2'b10;

  localparam logic [1:0] MUXB_D    = 2'b00;
  localparam logic [1:0] MUXB_X    = 2'b01;
  localparam logic [1:0] MUXB_REGB = 2'b10;
  localparam logic [1:0] MUXB_REGC = 2'b11;

endpackage

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: control FSM for the Goldschmidt fractional divider datapath.
// A start pulse in IDLE runs one initial-approximation step (INIT_D, INIT_N)
// followed by ITERS refinement iterations (ITER_N, ITER_D), the last of which
// skips its D step, and then pulses done for one cycle.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 division request, honoured only in IDLE
//   sel_muxa, sel_muxb    datapath operand-mux selects
//   enA, enB, enC         datapath register load enables
//   busy                  high from INIT_D through the last ITER_N
//   done                  one-cycle pulse; REGC holds the quotient
// All outputs are decoded from the state register only (Moore).
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int unsigned ITERS = 3  // legal range 1..15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] ITERS_CNT = 4'(ITERS);

  fpdiv_state_t state_reg, state_next;
  logic [3:0]   iter_cnt_reg, iter_cnt_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      iter_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      iter_cnt_reg <= iter_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    iter_cnt_next = iter_cnt_reg;
    sel_muxa      = MUXA_REGA;
    sel_muxb      = MUXB_D;
    enA           = 1'b0;
    enB           = 1'b0;
    enC           = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) state_next = INIT_D;
      end
      INIT_D: begin
        // D1 = d*IA into REGB, REGA = 2 - D1
        sel_muxa      = MUXA_IA;
        sel_muxb      = MUXB_D;
        enA           = 1'b1;
        enB           = 1'b1;
        busy          = 1'b1;
        iter_cnt_next = ITERS_CNT;
        state_next    = INIT_N;
      end
      INIT_N: begin
        // N1 = x*IA into REGC
        sel_muxa   = MUXA_IA;
        sel_muxb   = MUXB_X;
        enC        = 1'b1;
        busy       = 1'b1;
        state_next = ITER_N;
      end
      ITER_N: begin
        // N step runs before the D step so both use the same REGA factor;
        // the final iteration ends here without its D step.
        sel_muxa = MUXA_REGA;
        sel_muxb = MUXB_REGC;
        enC      = 1'b1;
        busy     = 1'b1;
        if (iter_cnt_reg == 4'd1) begin
          state_next = DONE;
        end else begin
          iter_cnt_next = iter_cnt_reg - 4'd1;
          state_next    = ITER_D;
        end
      end
      ITER_D: begin
        sel_muxa   = MUXA_REGA;
        sel_muxb   = MUXB_REGB;
        enA        = 1'b1;
        enB        = 1'b1;
        busy       = 1'b1;
        state_next = ITER_N;
      end
      DONE: begin
        // start is deliberately ignored here so requests cannot chain
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
